dpb_master_rd: RTL and testbench
================================

# dpb_master_rd

Drains completed packet slots from the MJPEG dual-port BRAM (port B) and serialises them into a byte stream for the UDP transmit path. Sits directly downstream of the MJPEG slot writer. Accepts its per-slot completion events (`wr_req` / `frame_down`) and queues them, because the writer never waits. Each slot is emitted header-first, then payload words MSB byte first, with `last` on the final valid byte.

## Interface
- `UDP_FRAME_MAX_SIZE_128`, 91: maximum payload words per slot (addresses 1..N; address 0 is the header).
- `RD_LAT`, 2: BRAM port-B read latency in cycles, address to data (CE plus output register).
- `REQ_FIFO_DEPTH`, 8: number of pending slot requests; must be ≤15 (16 ranks, one is always being written).
- `i_pclk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_wr_req`  in  1  slot-complete event from the writer (non-final slot).
- `i_frame_down`  in  1  frame-end event (final slot); may be held high for up to 9 cycles.
- `i_buf_rank`  in  4  rank of the completed slot.
- `i_buf_128cnt`  in  7  number of payload words in the slot (0..91).
- `i_buf_Bytecnt`  in  6  valid bytes in the last payload word; 0 means 16.
- `o_dpb_rd_b_addr`  out  11  {rank, word}.
- `o_dpb_rd_b_ce`  out  1  read enable.
- `i_dpb_rd_b_data`  in  128  read data.
- `o_tx_valid`  out  1  byte valid.
- `o_tx_data`  out  8  byte.
- `o_tx_sof`  out  1  first byte of a slot.
- `o_tx_last`  out  1  last byte of a slot.
- `o_tx_eof`  out  1  qualifies `o_tx_last`: the slot was a frame-end slot.
- `i_tx_ready`  in  1  downstream accepts the byte when `valid & ready`.
- `o_busy`  out  1  FSM not IDLE, or FIFO not empty.
- `o_overflow`  out  1  sticky: a request was dropped.

## Operation
- Event = rising edge of (`i_wr_req | i_frame_down`), detected against a registered copy. On an event, push {rank, 128cnt, Bytecnt, eof = `i_frame_down`} into the FIFO.
- Push while the FIFO is full: drop the event and set `o_overflow`. It stays set until reset.
- FSM states:
  - IDLE: if the FIFO is not empty, pop and latch the descriptor. Set word index to 0 (header), then go to RD.
  - RD: drive `addr = {rank, idx}` and `ce = 1` for one cycle, then go to WAIT.
  - WAIT: count RD_LAT cycles, then latch `i_dpb_rd_b_data` into a 128-bit shift register. Set bytes-left (16, or the last-word count), then go to SHIFT.
  - SHIFT: `o_tx_valid = 1`, `o_tx_data = shreg[127:120]`. On `valid & ready`, shift left by 8 and decrement bytes-left. On the last byte of a word: if this was the last word, go to IDLE; otherwise increment idx and go to RD.
- The last word is idx == 128cnt. Its byte count is (Bytecnt == 0) ? 16 : Bytecnt; its valid bytes are MSB-aligned. If 128cnt == 0, the header is the last word (16 bytes).
- `o_tx_sof` is high on the first byte of a slot. `o_tx_last` is high on the final byte. `o_tx_eof` equals the latched eof while `o_tx_last` is high, else 0.
- `o_tx_data`, `sof`, `last` and `eof` hold stable while `valid & ~ready`.
- No prefetch: there is a bubble of RD_LAT+1 cycles between words.
- Reset values: `o_tx_valid`, `o_tx_sof`, `o_tx_last`, `o_tx_eof`, `o_dpb_rd_b_ce`, `o_busy` and `o_overflow` are 0; `o_dpb_rd_b_addr` and `o_tx_data` are 0. FIFO empty, FSM IDLE.
- Reset mid-slot abandons the slot with no `last`.

## Timing
- Event sampled at cycle 0 → pushed (visible at cycle 1) → popped at cycle 1 → RD at cycle 2 → data latched at cycle 2+RD_LAT → first `o_tx_valid` at cycle RD_LAT+3. With the defaults that is cycle 5.
- Event arriving in the same cycle as a pop: push and pop both occur; the count is unchanged.
- Slot throughput with `ready` held high: 16 cycles per full word plus RD_LAT+1 cycles per word of overhead.

## Configuration
- `DPB_RD_HEADER_EN` defined: the header word (idx 0) is emitted as the first 16 bytes.
- Not defined: reading starts at idx 1, so `sof` goes on the first payload byte. A slot with 128cnt == 0 is popped and discarded with no output.

## Structure
- Shared package `dpb_pkg`: `RANK_W = 4`, `WORD_W = 7`, `BEAT_BYTES = 16`, the descriptor struct {rank, cnt128, bytecnt, eof}, and the FSM state enum.
- One sub-module, `dpb_req_fifo`: a synchronous FIFO of descriptors with push/pop/full/empty, reset asynchronously to empty.

## Test plan
- Non-final slot, rank 3, 128cnt = 2, Bytecnt = 0, ready always high → 48 bytes; reads addresses 0x180, 0x181, 0x182; `sof` on byte 0, `last` on byte 47, `eof` = 0.
- Frame-end via `i_frame_down` held 9 cycles, 128cnt = 1, Bytecnt = 5 → one event only; 21 bytes; the last 5 bytes are data[127:88]; `eof` = 1 with `last`.
- Back-pressure: `ready` toggles 1/0 each cycle → identical byte sequence, and data stays stable while stalled.
- Burst of 9 events while `ready` = 0, REQ_FIFO_DEPTH = 8 → the 9th is dropped, `o_overflow` = 1; releasing `ready` yields exactly 8 slots in order.
- Event in the same cycle as a pop → no loss; the descriptor order is preserved.
- Reset asserted mid-SHIFT → all outputs 0 immediately; after release `o_busy` = 0 and no bytes are emitted.

Source files
------------

// File: rtl/dpb_pkg.sv
// Shared types for the MJPEG BRAM port-B drain path.
// Descriptor layout, FSM states and slot geometry.
package dpb_pkg;

    localparam int RANK_W     = 4;
    localparam int WORD_W     = 7;
    localparam int BEAT_BYTES = 16;
    localparam int ADDR_W     = RANK_W + WORD_W;

    typedef struct packed {
        logic [RANK_W-1:0] rank;
        logic [WORD_W-1:0] cnt128;
        logic [5:0]        bytecnt;
        logic              eof;
    } dpb_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_SHIFT
    } dpb_state_t;

    // A byte count of zero in the last word means the word is full.
    function automatic logic [4:0] last_bytes(input logic [5:0] bc);
        return (bc == 6'd0) ? 5'(BEAT_BYTES) : bc[4:0];
    endfunction

endpackage

// File: rtl/dpb_master_rd_if.sv
// Writer events, BRAM port B and byte-stream signals of dpb_master_rd.
// master = the drain block, slave = its surroundings.
interface dpb_master_rd_if;

    logic         i_wr_req;
    logic         i_frame_down;
    logic [3:0]   i_buf_rank;
    logic [6:0]   i_buf_128cnt;
    logic [5:0]   i_buf_Bytecnt;

    logic [10:0]  o_dpb_rd_b_addr;
    logic         o_dpb_rd_b_ce;
    logic [127:0] i_dpb_rd_b_data;

    logic         o_tx_valid;
    logic [7:0]   o_tx_data;
    logic         o_tx_sof;
    logic         o_tx_last;
    logic         o_tx_eof;
    logic         i_tx_ready;

    modport master (
        input  i_wr_req, i_frame_down, i_buf_rank, i_buf_128cnt,
        input  i_buf_Bytecnt, i_dpb_rd_b_data, i_tx_ready,
        output o_dpb_rd_b_addr, o_dpb_rd_b_ce,
        output o_tx_valid, o_tx_data, o_tx_sof, o_tx_last, o_tx_eof
    );

    modport slave (
        output i_wr_req, i_frame_down, i_buf_rank, i_buf_128cnt,
        output i_buf_Bytecnt, i_dpb_rd_b_data, i_tx_ready,
        input  o_dpb_rd_b_addr, o_dpb_rd_b_ce,
        input  o_tx_valid, o_tx_data, o_tx_sof, o_tx_last, o_tx_eof
    );

endinterface

// File: rtl/dpb_req_fifo.sv
// Synchronous descriptor FIFO with show-ahead head output.
// Pointers and count reset asynchronously to empty.
module dpb_req_fifo
    import dpb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      i_pclk,
    input  logic      i_rst_n,
    input  logic      push,
    input  dpb_desc_t din,
    input  logic      pop,
    output dpb_desc_t dout,
    output logic      full,
    output logic      empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    dpb_desc_t      mem [DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  cnt;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_pclk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= nxt(wptr);
            if (do_pop)  rptr <= nxt(rptr);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dpb_master_rd.sv
// Drains completed BRAM packet slots into a byte stream, MSB byte first.
// Define DPB_RD_HEADER_EN to emit the header word (idx 0) ahead of payload.
module dpb_master_rd
    import dpb_pkg::*;
#(
    parameter int UDP_FRAME_MAX_SIZE_128 = 91,
    parameter int RD_LAT                 = 2,
    parameter int REQ_FIFO_DEPTH         = 8
) (
    input  logic            i_pclk,
    input  logic            i_rst_n,
    dpb_master_rd_if.master bus,
    output logic            o_busy,
    output logic            o_overflow
);

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WORD_W-1:0] MAXW = WORD_W'(UDP_FRAME_MAX_SIZE_128);

    dpb_state_t        st;
    dpb_desc_t         desc;
    dpb_desc_t         head;
    dpb_desc_t         din;
    logic [WORD_W-1:0] idx;
    logic [WCW-1:0]    wcnt;
    logic [127:0]      shreg;
    logic [4:0]        left;
    logic              first;
    logic              valid;
    logic              ce;
    logic [ADDR_W-1:0] addr;
    logic              lvl_q;
    logic              ovf;
    logic              lvl;
    logic              ev;
    logic              pop;
    logic              full;
    logic              empty;
    logic              skip;
    logic              last_word;

`ifdef DPB_RD_HEADER_EN
    localparam logic [WORD_W-1:0] FIRST_IDX = '0;
    assign skip = 1'b0;
`else
    localparam logic [WORD_W-1:0] FIRST_IDX = WORD_W'(1);
    assign skip = (head.cnt128 == '0);
`endif

    assign lvl = bus.i_wr_req | bus.i_frame_down;
    assign ev  = lvl & ~lvl_q;
    assign pop = (st == ST_IDLE) & ~empty;

    always_comb begin
        din         = '0;
        din.rank    = bus.i_buf_rank;
        din.cnt128  = (bus.i_buf_128cnt > MAXW) ? MAXW : bus.i_buf_128cnt;
        din.bytecnt = bus.i_buf_Bytecnt;
        din.eof     = bus.i_frame_down;
    end

    dpb_req_fifo #(
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_fifo (
        .i_pclk  (i_pclk),
        .i_rst_n (i_rst_n),
        .push    (ev),
        .din     (din),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lvl_q <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            lvl_q <= lvl;
            if (ev & full) ovf <= 1'b1;
        end
    end

    assign last_word = (idx == desc.cnt128);

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st    <= ST_IDLE;
            desc  <= '0;
            idx   <= '0;
            wcnt  <= '0;
            shreg <= '0;
            left  <= '0;
            first <= 1'b0;
            valid <= 1'b0;
            ce    <= 1'b0;
            addr  <= '0;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    if (!empty) begin
                        desc <= head;
                        if (!skip) begin
                            idx   <= FIRST_IDX;
                            addr  <= {head.rank, FIRST_IDX};
                            ce    <= 1'b1;
                            first <= 1'b1;
                            st    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    ce   <= 1'b0;
                    wcnt <= WCW'(RD_LAT - 1);
                    st   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wcnt == '0) begin
                        shreg <= bus.i_dpb_rd_b_data;
                        // A header-only slot still sends a full header word.
                        left  <= (last_word && idx != '0)
                                 ? last_bytes(desc.bytecnt)
                                 : 5'(BEAT_BYTES);
                        valid <= 1'b1;
                        st    <= ST_SHIFT;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bus.i_tx_ready) begin
                        shreg <= {shreg[119:0], 8'h00};
                        left  <= left - 5'd1;
                        first <= 1'b0;
                        if (left == 5'd1) begin
                            valid <= 1'b0;
                            if (last_word) begin
                                st <= ST_IDLE;
                            end else begin
                                idx  <= idx + 1'b1;
                                addr <= {desc.rank, idx + 1'b1};
                                ce   <= 1'b1;
                                st   <= ST_RD;
                            end
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_dpb_rd_b_addr = addr;
    assign bus.o_dpb_rd_b_ce   = ce;
    assign bus.o_tx_valid      = valid;
    assign bus.o_tx_data       = shreg[127:120];
    assign bus.o_tx_sof        = valid & first;
    assign bus.o_tx_last       = valid & last_word & (left == 5'd1);
    assign bus.o_tx_eof        = bus.o_tx_last & desc.eof;
    assign o_busy              = (st != ST_IDLE) | ~empty;
    assign o_overflow          = ovf;

endmodule

// File: tb/tb_dpb_master_rd.sv
// Directed bench for dpb_master_rd with a 2-cycle BRAM model.
module tb_dpb_master_rd;
    import dpb_pkg::*;

    localparam int RD_LAT = 2;
`ifdef DPB_RD_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct packed {
        logic       sof;
        logic       last;
        logic       eof;
        logic [7:0] d;
    } rx_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic ovf;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dpb_master_rd_if bus ();

    dpb_master_rd #(
        .UDP_FRAME_MAX_SIZE_128 (91),
        .RD_LAT                 (RD_LAT),
        .REQ_FIFO_DEPTH         (8)
    ) dut (
        .i_pclk     (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_busy     (busy),
        .o_overflow (ovf)
    );

    function automatic logic [7:0] bf(input logic [10:0] a, input int j);
        int v;
        v = int'(a) * 13 + j * 29 + 7;
        return v[7:0];
    endfunction

    function automatic logic [127:0] wd(input logic [10:0] a);
        logic [127:0] w;
        for (int j = 0; j < 16; j++) w[127-8*j -: 8] = bf(a, j);
        return w;
    endfunction

    logic [127:0] r1, r2;
    always @(posedge clk) begin
        if (bus.o_dpb_rd_b_ce) r1 <= wd(bus.o_dpb_rd_b_addr);
        r2 <= r1;
    end
    assign bus.i_dpb_rd_b_data = r2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    rx_t        rxq[$];
    rx_t        expq[$];
    logic [10:0] addrq[$];
    rx_t        cur;
    rx_t        prev;
    logic       stall;

    assign cur = {bus.o_tx_sof, bus.o_tx_last, bus.o_tx_eof, bus.o_tx_data};

    always @(negedge clk) begin
        if (!rst_n) begin
            stall <= 1'b0;
        end else begin
            if (stall) chk("stall_hold", {bus.o_tx_valid, cur}, {1'b1, prev});
            if (bus.o_tx_valid && bus.i_tx_ready) rxq.push_back(cur);
            if (bus.o_dpb_rd_b_ce) addrq.push_back(bus.o_dpb_rd_b_addr);
            stall <= bus.o_tx_valid & ~bus.i_tx_ready;
            prev  <= cur;
        end
    end

    task automatic exp_slot(input logic [3:0] r, input logic [6:0] c,
                            input logic [5:0] b, input bit e);
        bit f;
        int n;
        bit l;
        f = 1'b1;
        for (int idx = (HDR != 0) ? 0 : 1; idx <= int'(c); idx++) begin
            n = (idx == int'(c) && idx != 0) ? ((b == 0) ? 16 : int'(b)) : 16;
            for (int j = 0; j < n; j++) begin
                l = (idx == int'(c)) && (j == n - 1);
                expq.push_back({f, l, e & l, bf({r, 7'(idx)}, j)});
                f = 1'b0;
            end
        end
    endtask

    task automatic ev(input logic [3:0] r, input logic [6:0] c,
                      input logic [5:0] b, input bit fd, input int hold);
        bus.i_buf_rank    = r;
        bus.i_buf_128cnt  = c;
        bus.i_buf_Bytecnt = b;
        if (fd) bus.i_frame_down = 1'b1;
        else    bus.i_wr_req = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.i_wr_req     = 1'b0;
        bus.i_frame_down = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rxq.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("rx_budget", 32'(rxq.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("idle_budget", busy, 0);
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (!bus.o_tx_valid && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("valid_budget", bus.o_tx_valid, 1);
    endtask

    task automatic cmp(input string tag);
        int n;
        chk({tag, "_len"}, rxq.size(), expq.size());
        n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
        for (int i = 0; i < n; i++) chk(tag, rxq[i], expq[i]);
        rxq.delete();
        expq.delete();
    endtask

    initial begin
        int k;
        bus.i_wr_req      = 1'b0;
        bus.i_frame_down  = 1'b0;
        bus.i_buf_rank    = '0;
        bus.i_buf_128cnt  = '0;
        bus.i_buf_Bytecnt = '0;
        bus.i_tx_ready    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.o_tx_valid, 0);
        chk("rst_sof", bus.o_tx_sof, 0);
        chk("rst_last", bus.o_tx_last, 0);
        chk("rst_eof", bus.o_tx_eof, 0);
        chk("rst_ce", bus.o_dpb_rd_b_ce, 0);
        chk("rst_addr", bus.o_dpb_rd_b_addr, 0);
        chk("rst_data", bus.o_tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Slot 1: rank 3, two payload words, full last word.
        bus.i_buf_rank    = 4'd3;
        bus.i_buf_128cnt  = 7'd2;
        bus.i_buf_Bytecnt = 6'd0;
        bus.i_wr_req      = 1'b1;
        exp_slot(4'd3, 7'd2, 6'd0, 1'b0);
        @(posedge clk);
        #1;
        bus.i_wr_req = 1'b0;
        chk("lat_c1_valid", bus.o_tx_valid, 0);
        chk("lat_c1_busy", busy, 1);
        @(posedge clk);
        #1;
        chk("lat_c2_ce", bus.o_dpb_rd_b_ce, 1);
        chk("lat_c2_addr", bus.o_dpb_rd_b_addr, (HDR != 0) ? 11'h180 : 11'h181);
        @(posedge clk);
        #1;
        chk("lat_c3_valid", bus.o_tx_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_c4_valid", bus.o_tx_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_c5_valid", bus.o_tx_valid, 1);
        chk("lat_c5_sof", bus.o_tx_sof, 1);
        wait_rx(expq.size(), 400);
        wait_idle(50);
        chk("s1_nbytes", expq.size(), (HDR != 0) ? 48 : 32);
        cmp("s1_byte");
        chk("s1_naddr", addrq.size(), (HDR != 0) ? 3 : 2);
        for (int i = 0; i < addrq.size(); i++)
            chk("s1_addr", addrq[i], 11'h180 + 11'(i + 1 - HDR));
        addrq.delete();

        // Frame end held for 9 cycles must queue a single slot.
        exp_slot(4'd5, 7'd1, 6'd5, 1'b1);
        chk("s2_nbytes", expq.size(), (HDR != 0) ? 21 : 5);
        ev(4'd5, 7'd1, 6'd5, 1'b1, 9);
        wait_rx(expq.size(), 400);
        wait_idle(50);
        repeat (20) @(posedge clk);
        #1;
        chk("s2_tail", rxq.size() > 0 ? rxq[rxq.size()-1].d : 8'hxx,
            bf({4'd5, 7'd1}, 4));
        cmp("s2_byte");

        // Ready toggling every cycle.
        exp_slot(4'd6, 7'd2, 6'd9, 1'b0);
        ev(4'd6, 7'd2, 6'd9, 1'b0, 1);
        k = 0;
        while (rxq.size() < expq.size() && k < 600) begin
            @(posedge clk);
            #1;
            bus.i_tx_ready = ~bus.i_tx_ready;
            k++;
        end
        bus.i_tx_ready = 1'b1;
        wait_idle(50);
        cmp("s3_byte");

        // Zero-word slot: header only or discarded.
        exp_slot(4'd7, 7'd0, 6'd3, 1'b0);
        ev(4'd7, 7'd0, 6'd3, 1'b0, 1);
        wait_rx(expq.size(), 200);
        wait_idle(50);
        repeat (10) @(posedge clk);
        #1;
        cmp("s4_byte");

        // One slot stalled in flight, then 9 more events into 8 entries.
        bus.i_tx_ready = 1'b0;
        exp_slot(4'd1, 7'd1, 6'd2, 1'b0);
        ev(4'd1, 7'd1, 6'd2, 1'b0, 1);
        wait_valid(20);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_slot(4'(i + 2), 7'd1, 6'(i + 1), 1'b0);
            ev(4'(i + 2), 7'd1, 6'(i + 1), 1'b0, 1);
            if (i == 7) chk("ovf_at_8", ovf, 0);
        end
        chk("ovf_at_9", ovf, 1);
        bus.i_tx_ready = 1'b1;
        wait_rx(expq.size(), 2000);
        wait_idle(50);
        repeat (10) @(posedge clk);
        #1;
        cmp("s5_byte");
        chk("ovf_sticky", ovf, 1);

        // Push lands in the same cycle the FSM pops the next slot.
        bus.i_tx_ready = 1'b0;
        exp_slot(4'd9, 7'd1, 6'd4, 1'b0);
        exp_slot(4'd10, 7'd1, 6'd4, 1'b0);
        exp_slot(4'd11, 7'd1, 6'd4, 1'b0);
        ev(4'd9, 7'd1, 6'd4, 1'b0, 1);
        ev(4'd10, 7'd1, 6'd4, 1'b0, 1);
        bus.i_tx_ready = 1'b1;
        k = 0;
        while (!(bus.o_tx_valid && bus.o_tx_last) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        bus.i_tx_ready = 1'b0;
        chk("s6_last_seen", bus.o_tx_last, 1);
        @(posedge clk);
        #1;
        bus.i_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("s6_idle_valid", bus.o_tx_valid, 0);
        bus.i_buf_rank    = 4'd11;
        bus.i_buf_128cnt  = 7'd1;
        bus.i_buf_Bytecnt = 6'd4;
        bus.i_wr_req      = 1'b1;
        @(posedge clk);
        #1;
        bus.i_wr_req = 1'b0;
        wait_rx(expq.size(), 400);
        wait_idle(50);
        cmp("s6_byte");

        // Reset while a word is being shifted out.
        bus.i_tx_ready = 1'b0;
        ev(4'd12, 7'd2, 6'd0, 1'b0, 1);
        ev(4'd13, 7'd1, 6'd0, 1'b0, 1);
        wait_valid(20);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", bus.o_tx_valid, 0);
        chk("mr_sof", bus.o_tx_sof, 0);
        chk("mr_last", bus.o_tx_last, 0);
        chk("mr_eof", bus.o_tx_eof, 0);
        chk("mr_data", bus.o_tx_data, 0);
        chk("mr_ce", bus.o_dpb_rd_b_ce, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ovf", ovf, 0);
        rxq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.i_tx_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("mr_busy_after", busy, 0);
        chk("mr_no_bytes", rxq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
